// File: rtl/overlay_load_sched_if.sv
// overlay_load_sched_if: source byte stream, buffer write port and status bundle for overlay_load_sched.
// Ports (as interface signals):
//   iSTART/iSLOT       load request and target slot
//   iVBLANK            high while buffer writes are permitted
//   iSRC_DATA/iSRC_VALID/oSRC_READY   byte source handshake (R,G,B per pixel)
//   oWR_EN/oWR_ADDR/oWR_DATA          overlay buffer write port
//   oBUSY/oDONE/oERR/oACTIVE_SLOT     status
// master = source/controller side, slave = the scheduler.
interface overlay_load_sched_if #(
  parameter int SLOT_W = 2,
  parameter int ADDR_W = 9
);
  logic              iSTART;
  logic [SLOT_W-1:0] iSLOT;
  logic              iVBLANK;
  logic [7:0]        iSRC_DATA;
  logic              iSRC_VALID;
  logic              oSRC_READY;
  logic              oWR_EN;
  logic [ADDR_W-1:0] oWR_ADDR;
  logic [23:0]       oWR_DATA;
  logic              oBUSY;
  logic              oDONE;
  logic              oERR;
  logic [SLOT_W-1:0] oACTIVE_SLOT;
  modport master (
    output iSTART, iSLOT, iVBLANK, iSRC_DATA, iSRC_VALID,
    input  oSRC_READY, oWR_EN, oWR_ADDR, oWR_DATA, oBUSY, oDONE, oERR, oACTIVE_SLOT
  );
  modport slave (
    input  iSTART, iSLOT, iVBLANK, iSRC_DATA, iSRC_VALID,
    output oSRC_READY, oWR_EN, oWR_ADDR, oWR_DATA, oBUSY, oDONE, oERR, oACTIVE_SLOT
  );
endinterface

// File: rtl/overlay_load_sched.sv
// overlay_load_sched: loads WIDTHxHEIGHT RGB overlay images from a byte source into a slotted buffer during vblank.
// Ports:
//   iCLK   clock
//   iRST   asynchronous active-low reset
//   bus    overlay_load_sched_if.slave (request, byte source, buffer write port, status)
// Optional feature: define LOAD_TIMEOUT_EN to abort a load after TIMEOUT_CYC stalled source cycles.
module overlay_load_sched #(
  parameter int WIDTH       = 10,
  parameter int HEIGHT      = 10,
  parameter int NSLOT       = 4,
  parameter int SLOT_W      = 2,
  parameter int ADDR_W      = 9,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic                 iCLK,
  input logic                 iRST,
  overlay_load_sched_if.slave bus
);
  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int PIX_W = NPIX > 1 ? $clog2(NPIX) : 1;
  typedef enum logic [1:0] {IDLE, WAIT_VB, LOAD, COMMIT} state_t;
  state_t            state;
  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] active;
  logic [ADDR_W-1:0] base;
  logic [PIX_W-1:0]  pix;
  logic [1:0]        byte_idx;
  logic [7:0]        r_q;
  logic [7:0]        g_q;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              done;
  logic              err;
  logic              acc;
  logic              last;
  logic              timeout;
  assign bus.oSRC_READY   = state == LOAD && bus.iVBLANK;
  assign bus.oBUSY        = state != IDLE;
  assign bus.oWR_EN       = wr_en;
  assign bus.oWR_ADDR     = wr_addr;
  assign bus.oWR_DATA     = wr_data;
  assign bus.oDONE        = done;
  assign bus.oERR         = err;
  assign bus.oACTIVE_SLOT = active;
  assign acc  = bus.oSRC_READY && bus.iSRC_VALID;
  assign last = pix == PIX_W'(NPIX - 1);
`ifdef LOAD_TIMEOUT_EN
  localparam int ST_W = $clog2(TIMEOUT_CYC + 1);
  logic [ST_W-1:0] stall;
  logic            stall_cyc;
  // Only a source stall during an open vblank window counts; acceptance or leaving LOAD restarts it.
  assign stall_cyc = state == LOAD && bus.iVBLANK && !bus.iSRC_VALID;
  assign timeout   = stall_cyc && stall == ST_W'(TIMEOUT_CYC - 1);
  always_ff @(posedge iCLK or negedge iRST)
    if (!iRST) stall <= '0;
    else stall <= stall_cyc && !timeout ? stall + ST_W'(1) : '0;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge iCLK or negedge iRST)
    if (!iRST) begin
      state    <= IDLE;
      slot_q   <= '0;
      active   <= '0;
      base     <= '0;
      pix      <= '0;
      byte_idx <= '0;
      r_q      <= '0;
      g_q      <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      // A start is rejected when busy or when it targets the slot on display.
      err   <= (bus.iSTART && (state != IDLE || bus.iSLOT == active)) || timeout;
      case (state)
        IDLE:
          if (bus.iSTART && bus.iSLOT != active) begin
            slot_q   <= bus.iSLOT;
            base     <= ADDR_W'(bus.iSLOT) * ADDR_W'(NPIX);
            pix      <= '0;
            byte_idx <= '0;
            state    <= WAIT_VB;
          end
        WAIT_VB:
          if (bus.iVBLANK) state <= LOAD;
        LOAD:
          if (timeout) state <= IDLE;
          else if (!bus.iVBLANK) state <= WAIT_VB;
          else if (acc) begin
            byte_idx <= byte_idx == 2'd2 ? 2'd0 : byte_idx + 2'd1;
            if (byte_idx == 2'd0) r_q <= bus.iSRC_DATA;
            if (byte_idx == 2'd1) g_q <= bus.iSRC_DATA;
            if (byte_idx == 2'd2) begin
              wr_en   <= 1'b1;
              wr_addr <= base + ADDR_W'(pix);
              wr_data <= {r_q, g_q, bus.iSRC_DATA};
              pix     <= pix + PIX_W'(1);
              if (last) state <= COMMIT;
            end
          end
        COMMIT: begin
          active <= slot_q;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_overlay_load_sched.sv
// tb_overlay_load_sched: randomized self-checking bench for overlay_load_sched against a stream-level image model.
module tb_overlay_load_sched;
  localparam int W = 10, H = 10, N = W * H, NSLOT = 4, SLOT_W = 2, ADDR_W = 9, TO = 16;
  logic iCLK = 1'b0;
  logic iRST = 1'b0;
  always #5 iCLK = ~iCLK;
  overlay_load_sched_if #(.SLOT_W(SLOT_W), .ADDR_W(ADDR_W)) bus ();
  overlay_load_sched #(
    .WIDTH(W), .HEIGHT(H), .NSLOT(NSLOT), .SLOT_W(SLOT_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus(bus)
  );
  int tests = 0, fails = 0;
  logic [7:0]  img [3*N];
  logic [23:0] mem [NSLOT*N];
  int idx, nacc, nwr, ndone, nerr, viol, exp_slot, gap;
  bit src_on, vb_rand, busy_seen;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic drive();
    bus.iSRC_VALID = src_on && idx < 3*N && $urandom_range(99) >= gap;
    bus.iSRC_DATA  = idx < 3*N ? img[idx] : 8'h00;
    if (vb_rand) bus.iVBLANK = $urandom_range(3) != 0;
  endtask
  task automatic step();
    logic acc;
    @(negedge iCLK);
    if (bus.oSRC_READY && !bus.iVBLANK) viol++;
    if (bus.oBUSY) busy_seen = 1;
    acc = bus.iSRC_VALID && bus.oSRC_READY;
    if (acc) nacc++;
    if (bus.oWR_EN) begin
      if (nwr < N) begin
        check("wr_addr", 32'(bus.oWR_ADDR), 32'(exp_slot * N + nwr));
        check("wr_data", 32'(bus.oWR_DATA), 32'({img[3*nwr], img[3*nwr+1], img[3*nwr+2]}));
      end else check("extra_write", 32'(nwr), 32'(N - 1));
      mem[bus.oWR_ADDR] = bus.oWR_DATA;
      nwr++;
    end
    if (bus.oDONE) begin
      ndone++;
      check("busy_at_done", 32'(bus.oBUSY), 32'd0);
    end
    if (bus.oERR) nerr++;
    @(posedge iCLK);
    #1;
    if (acc) idx++;
    drive();
  endtask
  task automatic begin_load(int slot);
    exp_slot = slot; idx = 0; nacc = 0; nwr = 0; ndone = 0; nerr = 0; viol = 0; busy_seen = 0;
    drive();
  endtask
  task automatic pulse_start(int slot);
    bus.iSTART = 1'b1;
    bus.iSLOT  = SLOT_W'(slot);
    step();
    bus.iSTART = 1'b0;
  endtask
  task automatic wait_done(int budget);
    int c = 0;
    while (ndone == 0 && c < budget) begin
      step();
      c++;
    end
    if (ndone == 0) check("done_timeout", 32'd0, 32'd1);
  endtask
  task automatic rand_img();
    for (int i = 0; i < 3*N; i++) img[i] = 8'($urandom);
  endtask
  task automatic check_idle_outputs(string tag, int act);
    check({tag, "_ready"}, 32'(bus.oSRC_READY), 32'd0);
    check({tag, "_wr_en"}, 32'(bus.oWR_EN), 32'd0);
    check({tag, "_busy"}, 32'(bus.oBUSY), 32'd0);
    check({tag, "_done"}, 32'(bus.oDONE), 32'd0);
    check({tag, "_err"}, 32'(bus.oERR), 32'd0);
    check({tag, "_active"}, 32'(bus.oACTIVE_SLOT), 32'(act));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int c;
    bus.iSTART = 1'b0; bus.iSLOT = '0; bus.iVBLANK = 1'b0; bus.iSRC_VALID = 1'b0; bus.iSRC_DATA = '0;
    src_on = 0; vb_rand = 0; gap = 0; idx = 0;
    repeat (3) @(negedge iCLK);
    check_idle_outputs("reset", 0);
    check("reset_wr_addr", 32'(bus.oWR_ADDR), 32'd0);
    check("reset_wr_data", 32'(bus.oWR_DATA), 32'd0);
    @(posedge iCLK);
    #1;
    iRST = 1'b1;
    // Continuous load of slot 1 with pixel n = {n, n+1, n+2}.
    for (int n = 0; n < N; n++) for (int k = 0; k < 3; k++) img[3*n+k] = 8'(n + k);
    bus.iVBLANK = 1'b1;
    src_on = 1;
    begin_load(1);
    pulse_start(1);
    wait_done(2000);
    repeat (5) step();
    check("t1_writes", 32'(nwr), 32'(N));
    check("t1_bytes", 32'(nacc), 32'(3*N));
    check("t1_done_pulses", 32'(ndone), 32'd1);
    check("t1_active", 32'(bus.oACTIVE_SLOT), 32'd1);
    check("t1_addr150", 32'(mem[150]), 32'h00323334);
    check("t1_viol", 32'(viol), 32'd0);
    // Start aimed at the displayed slot is rejected.
    begin_load(1);
    pulse_start(1);
    repeat (5) step();
    check("t2_err", 32'(nerr), 32'd1);
    check("t2_writes", 32'(nwr), 32'd0);
    check("t2_bytes", 32'(nacc), 32'd0);
    check("t2_busy_seen", 32'(busy_seen), 32'd0);
    check("t2_active", 32'(bus.oACTIVE_SLOT), 32'd1);
    // Slot 2 with a long vblank gap after the G byte of pixel 50.
    rand_img();
    gap = 30;
    begin_load(2);
    pulse_start(2);
    c = 0;
    while (nacc < 152 && c < 3000) begin
      step();
      c++;
    end
    check("t3_reach152", 32'(nacc), 32'd152);
    bus.iVBLANK = 1'b0;
    repeat (500) step();
    check("t3_hold_bytes", 32'(nacc), 32'd152);
    check("t3_hold_writes", 32'(nwr), 32'd50);
    bus.iVBLANK = 1'b1;
    wait_done(3000);
    repeat (3) step();
    check("t3_writes", 32'(nwr), 32'(N));
    check("t3_bytes", 32'(nacc), 32'(3*N));
    check("t3_addr250", 32'(mem[250]), 32'({img[150], img[151], img[152]}));
    check("t3_active", 32'(bus.oACTIVE_SLOT), 32'd2);
    check("t3_viol", 32'(viol), 32'd0);
    // Slot 1 with random vblank and gaps; an intruding start for slot 3 is rejected.
    rand_img();
    gap = 25;
    vb_rand = 1;
    begin_load(1);
    pulse_start(1);
    c = 0;
    while (nwr < 30 && c < 3000) begin
      step();
      c++;
    end
    pulse_start(3);
    wait_done(6000);
    vb_rand = 0;
    bus.iVBLANK = 1'b1;
    repeat (3) step();
    check("t4_err", 32'(nerr), 32'd1);
    check("t4_writes", 32'(nwr), 32'(N));
    check("t4_bytes", 32'(nacc), 32'(3*N));
    check("t4_active", 32'(bus.oACTIVE_SLOT), 32'd1);
    check("t4_viol", 32'(viol), 32'd0);
    // Reset in the middle of a slot-3 load, then a fresh slot-3 load.
    rand_img();
    gap = 0;
    begin_load(3);
    pulse_start(3);
    c = 0;
    while (nwr < 40 && c < 3000) begin
      step();
      c++;
    end
    iRST = 1'b0;
    @(negedge iCLK);
    check_idle_outputs("t5_rst", 0);
    @(posedge iCLK);
    #1;
    iRST = 1'b1;
    rand_img();
    begin_load(3);
    pulse_start(3);
    wait_done(2000);
    repeat (3) step();
    check("t5_writes", 32'(nwr), 32'(N));
    check("t5_addr300", 32'(mem[300]), 32'({img[0], img[1], img[2]}));
    check("t5_active", 32'(bus.oACTIVE_SLOT), 32'd3);
`ifdef LOAD_TIMEOUT_EN
    // Source dries up after 30 bytes inside vblank: abort after TO stall cycles.
    rand_img();
    begin_load(0);
    pulse_start(0);
    c = 0;
    while (nacc < 30 && c < 1000) begin
      step();
      c++;
    end
    src_on = 0;
    bus.iSRC_VALID = 1'b0;
    c = 0;
    while (nerr == 0 && c < 100) begin
      step();
      c++;
    end
    check("to_cycles", 32'(c), 32'(TO + 1));
    check("to_err", 32'(nerr), 32'd1);
    check("to_writes", 32'(nwr), 32'd10);
    check("to_done", 32'(ndone), 32'd0);
    check("to_busy", 32'(bus.oBUSY), 32'd0);
    check("to_active", 32'(bus.oACTIVE_SLOT), 32'd3);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
